// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state encoding and SPI mode decode for the SPI slave transceiver
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic sample_rise;
        logic launch_rise;
    } spi_edge_sel_t;

    // Leading edge is rising for cpol=0; cpha=1 moves sampling to the trailing edge.
    function automatic spi_edge_sel_t spi_mode_decode(input logic cpol, input logic cpha);
        spi_edge_sel_t sel;
        sel.sample_rise = ~(cpol ^ cpha);
        sel.launch_rise = cpol ^ cpha;
        return sel;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop synchronisers plus history flop for the SPI pins
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // cs_n resets high so a deasserted chip select never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/spi_slave_xcvr_param.sv
// rtl/spi_slave_xcvr_param.sv - parametrised SPI slave with runtime mode, TX holding buffer and error reporting
module spi_slave_xcvr_param
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 16,
    parameter bit                    MSB_FIRST      = 1'b1,
    parameter int                    TIMEOUT_CYCLES = 2400,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  spi_clk_error,
    output logic                  busy
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    spi_state_t            state, state_next;
    spi_edge_sel_t         edge_sel;
    logic                  sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
    logic                  cpol_q, cpha_q;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         to_cnt;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift, hold_data;
    logic [DATA_WIDTH-1:0] rx_next, tx_next;
    logic                  hold_full, load_pend, rx_pend;
    logic                  active, sample_evt, launch_evt, load_evt, timeout_hit, hold_wr;

    spi_pin_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (spi_sck),
        .cs_n     (spi_cs_n),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A CS release takes priority over any SCK edge or timeout seen in the same cycle.
    always_comb begin
        edge_sel    = spi_mode_decode(cpol_q, cpha_q);
        active      = (state == ST_ACTIVE) && !cs_rise;
        sample_evt  = active && (edge_sel.sample_rise ? sck_rise : sck_fall);
        launch_evt  = active && (edge_sel.launch_rise ? sck_rise : sck_fall);
        timeout_hit = active && !sck_rise && !sck_fall && (to_cnt == TO_LAST);
        load_evt    = ((state == ST_IDLE) && cs_fall && !cpha) || (launch_evt && load_pend);
        hold_wr     = tx_valid && !hold_full;
        rx_next     = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
        tx_next     = MSB_FIRST ? {tx_shift[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, tx_shift[DATA_WIDTH-1:1]};
        state_next  = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (cs_rise)          state_next = ST_IDLE;
                else if (timeout_hit) state_next = ST_ERROR;
            end
            ST_ERROR:  if (cs_rise) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            load_pend     <= 1'b0;
            rx_pend       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_abort   <= 1'b0;
            spi_clk_error <= 1'b0;
        end else begin
            rx_valid      <= rx_pend;
            rx_pend       <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_abort   <= 1'b0;
            spi_clk_error <= timeout_hit;
            if (rx_pend) rx_data <= rx_shift;

            if ((state == ST_IDLE) && cs_fall) begin
                cpol_q    <= cpol;
                cpha_q    <= cpha;
                bit_cnt   <= '0;
                load_pend <= cpha;
            end

            // The final sample of a word arms a load on the next launch edge.
            if (sample_evt) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    rx_pend   <= 1'b1;
                    load_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (launch_evt) begin
                if (load_pend) load_pend <= 1'b0;
                else           tx_shift  <= tx_next;
            end

            if (load_evt) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end

            if (hold_wr) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if ((state == ST_ACTIVE) && cs_rise) begin
                frame_abort <= (bit_cnt != '0);
                bit_cnt     <= '0;
            end
            if (timeout_hit) bit_cnt <= '0;

            if ((state != ST_ACTIVE) || sck_rise || sck_fall) to_cnt <= '0;
            else                                              to_cnt <= to_cnt + 1'b1;
        end
    end

    assign spi_miso    = MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0];
    assign spi_miso_oe = (state == ST_ACTIVE);
    assign tx_ready    = !hold_full;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_xcvr_param.sv
// tb/tb_spi_slave_xcvr_param.sv - directed and randomised checks of the SPI slave against an SPI master model
module tb_spi_slave_xcvr_param;

    localparam int          H      = 8;
    localparam logic [15:0] IDLE16 = 16'hD00D;

    logic clk = 1'b0, rst = 1'b1;
    logic sck = 1'b0, mosi = 1'b0, cs16_n = 1'b1, cs8_n = 1'b1;
    logic cpol_pin = 1'b0, cpha_pin = 1'b0;
    logic cpol_m = 1'b0, cpha_m = 1'b0, sel8 = 1'b0;
    logic [15:0] tx_data16 = '0;
    logic [7:0]  tx_data8 = '0;
    logic tx_valid16 = 1'b0, tx_valid8 = 1'b0;

    logic miso16, oe16, tx_ready16, rx_valid16, und16, abt16, err16, busy16;
    logic [15:0] rx_data16;
    logic miso8, oe8, tx_ready8, rx_valid8, und8, abt8, err8, busy8;
    logic [7:0] rx_data8;

    int n_assert = 0, n_fail = 0;
    int n_und16 = 0, n_abt16 = 0, n_err16 = 0;
    logic [15:0] rxq16[$];
    logic [7:0]  rxq8[$];

    always #5 clk = ~clk;

    spi_slave_xcvr_param #(.DATA_WIDTH(16), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(64), .TX_IDLE(IDLE16)) dut16 (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs16_n), .spi_mosi(mosi),
        .spi_miso(miso16), .spi_miso_oe(oe16), .cpol(cpol_pin), .cpha(cpha_pin),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_underrun(und16),
        .frame_abort(abt16), .spi_clk_error(err16), .busy(busy16)
    );

    spi_slave_xcvr_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(64), .TX_IDLE(8'h00)) dut8 (
        .clk(clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs8_n), .spi_mosi(mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .cpol(cpol_pin), .cpha(cpha_pin),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_underrun(und8),
        .frame_abort(abt8), .spi_clk_error(err8), .busy(busy8)
    );

    always @(negedge clk) begin
        if (rx_valid16) rxq16.push_back(rx_data16);
        if (rx_valid8)  rxq8.push_back(rx_data8);
        if (und16) n_und16 <= n_und16 + 1;
        if (abt16) n_abt16 <= n_abt16 + 1;
        if (err16) n_err16 <= n_err16 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic cur_miso();
        return sel8 ? miso8 : miso16;
    endfunction

    task automatic set_mode(input logic [1:0] m);
        cpol_m = m[1]; cpha_m = m[0];
        cpol_pin = m[1]; cpha_pin = m[0];
        sck = m[1];
        wait_clk(4);
    endtask

    task automatic cs_on();
        if (sel8) cs8_n = 1'b0;
        else      cs16_n = 1'b0;
    endtask

    task automatic cs_off();
        wait_clk(H);
        cs8_n = 1'b1;
        cs16_n = 1'b1;
        wait_clk(6);
    endtask

    task automatic push(input logic [31:0] w);
        int n = 0;
        while ((sel8 ? tx_ready8 : tx_ready16) !== 1'b1 && n < 100) begin
            wait_clk(1);
            n++;
        end
        check("push_ready_wait", 32'(n < 100), 32'd1);
        if (sel8) begin tx_data8 = w[7:0];   tx_valid8 = 1'b1;  end
        else      begin tx_data16 = w[15:0]; tx_valid16 = 1'b1; end
        wait_clk(1);
        tx_valid8 = 1'b0;
        tx_valid16 = 1'b0;
    endtask

    // SPI master: drives mosi on its launch edge, captures miso at its sample edge.
    task automatic xfer(input logic [31:0] mo, input int nbits, input bit tog, output logic [31:0] mi);
        int w = sel8 ? 8 : 16;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx = sel8 ? i : (w - 1 - i);
            if (tog && i == 5) begin cpol_pin = ~cpol_pin; cpha_pin = ~cpha_pin; end
            if (!cpha_m) begin
                mosi = mo[idx];
                wait_clk(H);
                mi[idx] = cur_miso();
                sck = ~cpol_m;
                wait_clk(H);
                sck = cpol_m;
            end else begin
                wait_clk(H);
                sck = ~cpol_m;
                mosi = mo[idx];
                wait_clk(H);
                mi[idx] = cur_miso();
                sck = cpol_m;
            end
        end
    endtask

    initial begin
        logic [31:0] mi, mi1, mi2, mi3, mo, tx, a, b, m1, m2, m3;
        logic [15:0] last16;
        logic [7:0]  last8;
        logic [1:0]  md;
        int und0, abt0, err0, first_err, loads, avail;

        wait_clk(3);
        @(negedge clk);
        check("reset16_flags", {miso16, oe16, tx_ready16, rx_valid16, und16, abt16, err16, busy16}, 8'b0010_0000);
        check("reset16_rx_data", rx_data16, 16'h0);
        rst = 1'b0;
        wait_clk(4);

        // Mode 0 single word
        sel8 = 1'b0;
        set_mode(2'd0);
        rxq16.delete();
        push(16'hA5C3);
        check("m0_tx_ready_full", tx_ready16, 1'b0);
        cs_on();
        wait_clk(6);
        check("m0_tx_ready_after_load", tx_ready16, 1'b1);
        xfer(16'h1234, 16, 1'b0, mi);
        cs_off();
        check("m0_rx_count", rxq16.size(), 1);
        if (rxq16.size() > 0) check("m0_rx_word", rxq16[0], 16'h1234);
        check("m0_miso_word", mi, 16'hA5C3);
        check("m0_busy_idle", busy16, 1'b0);
        last16 = 16'h1234;

        // Modes 1..3 with pins toggled mid-frame
        for (int m = 1; m < 4; m++) begin
            md = 2'(m);
            set_mode(md);
            rxq16.delete();
            push(16'h0F0F);
            cs_on();
            xfer(16'hBEEF, 16, 1'b1, mi);
            cs_off();
            check($sformatf("mode%0d_rx_count", m), rxq16.size(), 1);
            if (rxq16.size() > 0) check($sformatf("mode%0d_rx_word", m), rxq16[0], 16'hBEEF);
            check($sformatf("mode%0d_miso_word", m), mi, 16'h0F0F);
        end
        last16 = 16'hBEEF;

        // Three words in one CS, mode 1, refill only after the first word
        set_mode(2'd1);
        rxq16.delete();
        und0 = n_und16;
        a = $urandom; b = $urandom; m1 = $urandom; m2 = $urandom; m3 = $urandom;
        push(a);
        cs_on();
        xfer(m1, 16, 1'b0, mi1);
        push(b);
        xfer(m2, 16, 1'b0, mi2);
        xfer(m3, 16, 1'b0, mi3);
        cs_off();
        check("b2b_rx_count", rxq16.size(), 3);
        if (rxq16.size() == 3) begin
            check("b2b_rx0", rxq16[0], m1[15:0]);
            check("b2b_rx1", rxq16[1], m2[15:0]);
            check("b2b_rx2", rxq16[2], m3[15:0]);
        end
        check("b2b_miso0", mi1[15:0], a[15:0]);
        check("b2b_miso1", mi2[15:0], b[15:0]);
        check("b2b_miso2_idle", mi3[15:0], IDLE16);
        check("b2b_underruns", n_und16 - und0, 1);
        last16 = m3[15:0];

        // CS released after 7 bits
        set_mode(2'd0);
        rxq16.delete();
        abt0 = n_abt16;
        cs_on();
        xfer($urandom, 7, 1'b0, mi);
        cs_off();
        check("abort_pulses", n_abt16 - abt0, 1);
        check("abort_no_rx", rxq16.size(), 0);
        check("abort_rx_hold", rx_data16, last16);
        check("abort_idle", busy16, 1'b0);

        // SCK stalls mid-word
        err0 = n_err16;
        first_err = -1;
        cs_on();
        xfer($urandom, 5, 1'b0, mi);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (err16 === 1'b1 && first_err < 0) first_err = k;
        end
        check("timeout_latency", first_err, 67);
        check("timeout_pulses", n_err16 - err0, 1);
        check("timeout_oe_off", oe16, 1'b0);
        check("timeout_busy_error", busy16, 1'b1);
        cs_off();
        check("timeout_idle_after_cs", busy16, 1'b0);

        // Randomised single-word frames; buffer model: loads per frame, words available
        for (int r = 0; r < 4; r++) begin
            md = 2'($urandom_range(0, 3));
            set_mode(md);
            rxq16.delete();
            mo = $urandom; tx = $urandom;
            und0 = n_und16;
            push(tx);
            cs_on();
            xfer(mo, 16, 1'b0, mi);
            cs_off();
            loads = 1 + (md[0] ? 0 : 1);
            avail = 1;
            check($sformatf("rand%0d_rx", r), (rxq16.size() == 1) ? rxq16[0] : 16'hxxxx, mo[15:0]);
            check($sformatf("rand%0d_miso", r), mi[15:0], tx[15:0]);
            check($sformatf("rand%0d_underruns", r), n_und16 - und0, loads - avail);
        end

        // 8-bit LSB-first instance
        sel8 = 1'b1;
        set_mode(2'd0);
        rxq8.delete();
        tx = $urandom;
        push(tx);
        cs_on();
        xfer(32'h01, 8, 1'b0, mi);
        cs_off();
        check("w8_rx_count", rxq8.size(), 1);
        if (rxq8.size() > 0) check("w8_rx_word", rxq8[0], 8'h01);
        check("w8_miso_word", mi[7:0], tx[7:0]);

        set_mode(2'd3);
        rxq8.delete();
        mo = $urandom; tx = $urandom;
        push(tx);
        cs_on();
        xfer(mo, 8, 1'b0, mi);
        cs_off();
        check("w8_m3_rx", (rxq8.size() == 1) ? rxq8[0] : 8'hxx, mo[7:0]);
        check("w8_m3_miso", mi[7:0], tx[7:0]);
        last8 = mo[7:0];

        // Reset mid-word
        set_mode(2'd0);
        push(8'hFF);
        cs_on();
        wait_clk(6);
        push(8'h3C);
        check("rst_pre_tx_ready", tx_ready8, 1'b0);
        xfer($urandom, 3, 1'b0, mi);
        check("rst_pre_miso", miso8, 1'b1);
        check("rst_pre_busy", busy8, 1'b1);
        check("rst_pre_rx_data", rx_data8, last8);
        rst = 1'b1;
        cs8_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_flags", {miso8, oe8, tx_ready8, rx_valid8, und8, abt8, err8, busy8}, 8'b0010_0000);
        check("rst_mid_rx_data", rx_data8, 8'h00);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
